// File: rtl/fg_cfg_writer.sv
// Host-side writer for the function generator's parallel config-register bus.
// Walks the selected registers in ascending address order with setup/strobe/release timing.
module fg_cfg_writer #(
  parameter int unsigned SETUP_CYCLES   = 2,
  parameter int unsigned STROBE_CYCLES  = 4,
  parameter int unsigned RELEASE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [63:0] cfg_i,
  input  logic [7:0]  mask_i,
  output logic [7:0]  data_o,
  output logic [2:0]  addr_o,
  output logic        wr_en_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, RELEASE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [63:0] cfg_q, cfg_d;
  logic [7:0]  mask_q, mask_d;
  logic [7:0]  mask_rem;
  logic [2:0]  sel_d;
  logic        load_bus;
  logic        finish;
  logic [7:0]  data_d;
  logic [2:0]  addr_d;
  logic        wr_en_d, busy_d, done_d;

  function automatic logic [2:0] lowest_bit(input logic [7:0] m);
    lowest_bit = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) lowest_bit = 3'(i);
    end
  endfunction

  // Register n lives in the top byte once the word is shifted left by 8n.
  function automatic logic [7:0] cfg_byte(input logic [63:0] cfg, input logic [2:0] n);
    logic [63:0] sh;
    sh = cfg << {n, 3'b000};
    return sh[63:56];
  endfunction

  // addr_o always holds the index of the register currently being written.
  assign mask_rem = mask_q & ~(8'd1 << addr_o);

  // NOTE: synchronous reset clears every register, including the latched word,
  // and non-blocking assignments keep all state updates on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cfg_q   <= '0;
      mask_q  <= '0;
      data_o  <= '0;
      addr_o  <= '0;
      wr_en_o <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cfg_q   <= cfg_d;
      mask_q  <= mask_d;
      data_o  <= data_d;
      addr_o  <= addr_d;
      wr_en_o <= wr_en_d;
      busy_o  <= busy_d;
      done_o  <= done_d;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cfg_d    = cfg_q;
    mask_d   = mask_q;
    sel_d    = addr_o;
    load_bus = 1'b0;
    finish   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          cfg_d  = cfg_i;
          mask_d = mask_i;
          if (mask_i != 8'd0) begin
            sel_d    = lowest_bit(mask_i);
            state_d  = SETUP;
            cnt_d    = 8'(SETUP_CYCLES);
            load_bus = 1'b1;
          end else begin
            finish = 1'b1;
          end
        end
      end
      SETUP: begin
        if (cnt_q == 8'd1) begin
          state_d = STROBE;
          cnt_d   = 8'(STROBE_CYCLES);
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      STROBE: begin
        if (cnt_q == 8'd1) begin
          state_d = RELEASE;
          cnt_d   = 8'(RELEASE_CYCLES);
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RELEASE: begin
        if (cnt_q == 8'd1) begin
          mask_d = mask_rem;
          if (mask_rem != 8'd0) begin
            sel_d    = lowest_bit(mask_rem);
            state_d  = SETUP;
            cnt_d    = 8'(SETUP_CYCLES);
            load_bus = 1'b1;
          end else begin
            state_d = IDLE;
            cnt_d   = 8'd0;
            finish  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; data/addr move only on SETUP entry.
  always_comb begin
    data_d  = data_o;
    addr_d  = addr_o;
    if (load_bus) begin
      data_d = cfg_byte(cfg_d, sel_d);
      addr_d = sel_d;
    end
    wr_en_d = (state_d == STROBE);
    busy_d  = (state_d != IDLE);
    done_d  = finish;
  end

endmodule

// File: tb/tb_fg_cfg_writer.sv
// Self-checking bench for fg_cfg_writer: table-driven sequences plus hand-written
// corner cases, with a bus monitor popping expected writes from a scoreboard queue.
module tb_fg_cfg_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [63:0] cfg_i;
  logic [7:0]  mask_i;
  logic [7:0]  data_o;
  logic [2:0]  addr_o;
  logic        wr_en_o;
  logic        busy_o;
  logic        done_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    logic [63:0] cfg;
    logic [7:0]  mask;
    int          exp_busy;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vecs[6];

  fg_cfg_writer #(
    .SETUP_CYCLES(2),
    .STROBE_CYCLES(4),
    .RELEASE_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start_i(start_i),
    .cfg_i(cfg_i),
    .mask_i(mask_i),
    .data_o(data_o),
    .addr_o(addr_o),
    .wr_en_o(wr_en_o),
    .busy_o(busy_o),
    .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_model(input logic [63:0] cfg, input logic [7:0] mask);
    wr_t w;
    for (int n = 0; n < 8; n++) begin
      if (mask[n]) begin
        w.addr = 3'(n);
        w.data = cfg[63-8*n -: 8];
        exp_q.push_back(w);
      end
    end
  endtask

  // Counts busy cycles until done_o is seen; the current cycle is the first one examined.
  task automatic wait_done(output int busy_cnt, output int lat, output bit ok);
    bit stop;
    busy_cnt = 0;
    lat      = 0;
    ok       = 1'b0;
    stop     = 1'b0;
    for (int i = 0; i < 2000 && !stop; i++) begin
      if (done_o) begin
        ok   = 1'b1;
        stop = 1'b1;
      end else begin
        if (busy_o) busy_cnt++;
        tick();
        lat++;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: done_o never rose within 2000 cycles");
    end
  endtask

  task automatic run_seq(input logic [63:0] cfg, input logic [7:0] mask, input int exp_busy);
    int bc, lat;
    bit ok;
    push_model(cfg, mask);
    cfg_i   = cfg;
    mask_i  = mask;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    cfg_i   = ~cfg;
    mask_i  = ~mask;
    wait_done(bc, lat, ok);
    if (ok) begin
      check("busy_cycles", 64'(bc), 64'(exp_busy));
      check("done_latency", 64'(lat), 64'(exp_busy));
      check("busy_low_at_done", 64'(busy_o), 64'd0);
      tick();
      check("done_one_cycle", 64'(done_o), 64'd0);
    end
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  // Bus monitor: each rising wr_en_o consumes one expected write.
  logic       in_wr = 1'b0;
  int         strobe_len = 0;
  logic [2:0] cap_addr;
  logic [7:0] cap_data;

  always @(negedge clk) begin
    wr_t e;
    if (rst_n !== 1'b1) begin
      in_wr = 1'b0;
    end else if (wr_en_o && !in_wr) begin
      in_wr      = 1'b1;
      strobe_len = 1;
      cap_addr   = addr_o;
      cap_data   = data_o;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d data 0x%0h with no write expected", addr_o, data_o);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(addr_o), 64'(e.addr));
        check("wr_data", 64'(data_o), 64'(e.data));
      end
    end else if (wr_en_o) begin
      strobe_len++;
    end else if (in_wr) begin
      in_wr = 1'b0;
      check("strobe_len", 64'(strobe_len), 64'd4);
      check("bus_hold_after_strobe", {53'd0, addr_o, data_o}, {53'd0, cap_addr, cap_data});
    end
  end

  initial begin
    int bc, lat, a_busy;
    bit ok;

    vecs[0] = '{64'h0102_0304_0506_0708, 8'hFF, 80};
    vecs[1] = '{64'hAA00_0000_0000_0055, 8'h81, 20};
    vecs[2] = '{64'hDEAD_BEEF_CAFE_F00D, 8'h00, 0};
    vecs[3] = '{64'h1122_3344_5566_7788, 8'h24, 20};
    vecs[4] = '{64'h0F1E_2D3C_4B5A_6978, 8'h80, 10};
    vecs[5] = '{64'h0011_2233_4455_6677, 8'h01, 10};

    // Reset with start held high.
    rst_n   = 1'b0;
    start_i = 1'b1;
    cfg_i   = 64'h0102_0304_0506_0708;
    mask_i  = 8'hFF;
    repeat (3) tick();
    check("rst_outputs", {50'd0, data_o, addr_o, wr_en_o, busy_o, done_o}, 64'd0);
    rst_n   = 1'b1;
    start_i = 1'b0;
    repeat (4) tick();
    check("idle_outputs", {50'd0, data_o, addr_o, wr_en_o, busy_o, done_o}, 64'd0);

    for (int v = 0; v < 6; v++) begin
      run_seq(vecs[v].cfg, vecs[v].mask, vecs[v].exp_busy);
      tick();
    end

    // Cycle-level timing of a single write (register 2).
    push_model(64'h0102_0304_0506_0708, 8'h04);
    cfg_i   = 64'h0102_0304_0506_0708;
    mask_i  = 8'h04;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("single_addr", 64'(addr_o), 64'd2);
    check("single_data", 64'(data_o), 64'h03);
    for (int i = 0; i < 10; i++) begin
      check("single_wr_en", 64'(wr_en_o), 64'(i >= 2 && i < 6));
      check("single_busy", 64'(busy_o), 64'd1);
      tick();
    end
    check("single_done", 64'(done_o), 64'd1);
    check("single_busy_end", 64'(busy_o), 64'd0);
    check("single_hold_data", 64'(data_o), 64'h03);
    tick();

    // Mid-sequence start ignored, then start held for a back-to-back sequence.
    push_model(64'h1111_2222_3333_4444, 8'h0F);
    push_model(64'h5566_7788_99AA_BBCC, 8'h30);
    cfg_i   = 64'h1111_2222_3333_4444;
    mask_i  = 8'h0F;
    start_i = 1'b1;
    tick();
    a_busy = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy_o) a_busy++;
      start_i = (i == 5);
      cfg_i   = (i == 5) ? 64'hFFEE_DDCC_BBAA_9988 : 64'h0;
      mask_i  = (i == 5) ? 8'hFF : 8'h00;
      tick();
    end
    cfg_i   = 64'h5566_7788_99AA_BBCC;
    mask_i  = 8'h30;
    start_i = 1'b1;
    wait_done(bc, lat, ok);
    check("first_seq_busy", 64'(a_busy + bc), 64'd40);
    tick();
    check("b2b_started", 64'(busy_o), 64'd1);
    check("b2b_no_done", 64'(done_o), 64'd0);
    start_i = 1'b0;
    cfg_i   = 64'h0;
    wait_done(bc, lat, ok);
    check("second_seq_busy", 64'(bc), 64'd20);
    check("b2b_queue_drained", 64'(exp_q.size()), 64'd0);
    tick();

    // Reset during the strobe of register 3.
    push_model(64'hA0A1_A2A3_A4A5_A6A7, 8'h0F);
    cfg_i   = 64'hA0A1_A2A3_A4A5_A6A7;
    mask_i  = 8'hFF;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (wr_en_o && addr_o == 3'd3) ok = 1'b1;
      else tick();
    end
    check("reached_strobe_addr3", 64'(ok), 64'd1);
    tick();
    rst_n = 1'b0;
    tick();
    check("midrst_outputs", {50'd0, data_o, addr_o, wr_en_o, busy_o, done_o}, 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midrst_quiet", {61'd0, wr_en_o, busy_o, done_o}, 64'd0);
    end
    check("midrst_queue", 64'(exp_q.size()), 64'd0);

    run_seq(vecs[0].cfg, vecs[0].mask, vecs[0].exp_busy);
    repeat (3) tick();
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
